// File: rtl/ctx_pkg.sv
// ctx_pkg: shared types, register constants and entry packing for the SNES snoop queue.
package ctx_pkg;
  typedef enum logic [2:0] {RG_WRAM, RG_VRAM, RG_CGRAM, RG_OAM, RG_PPU, RG_CPU} region_e;
  localparam logic [23:0] OFS_CGRAM = 24'h000000;
  localparam logic [23:0] OFS_OAM   = 24'h000200;
  localparam logic [23:0] OFS_PPU   = 24'h000500;
  localparam logic [23:0] OFS_CPU   = 24'h000700;
  localparam logic [7:0] PA_OAMADDL = 8'h02;
  localparam logic [7:0] PA_OAMADDH = 8'h03;
  localparam logic [7:0] PA_OAMDATA = 8'h04;
  localparam logic [7:0] PA_VMAIN   = 8'h15;
  localparam logic [7:0] PA_VMADDL  = 8'h16;
  localparam logic [7:0] PA_VMADDH  = 8'h17;
  localparam logic [7:0] PA_VMDATAL = 8'h18;
  localparam logic [7:0] PA_VMDATAH = 8'h19;
  localparam logic [7:0] PA_CGADD   = 8'h21;
  localparam logic [7:0] PA_CGDATA  = 8'h22;
  localparam logic [7:0] PA_OAMREAD = 8'h38;
  localparam logic [7:0] PA_VMRDL   = 8'h39;
  localparam logic [7:0] PA_VMRDH   = 8'h3A;
  localparam logic [7:0] PA_WMDATA  = 8'h80;
  localparam logic [7:0] PA_WMADDL  = 8'h81;
  localparam logic [7:0] PA_WMADDM  = 8'h82;
  localparam logic [7:0] PA_WMADDH  = 8'h83;
  localparam int ENTRY_W = 41;
  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        word;
  } entry_t;
  function automatic entry_t make_entry(input logic [23:0] a, input logic [15:0] d, input logic w);
    entry_t e;
    e.addr = a;
    e.data = d;
    e.word = w;
    return e;
  endfunction
  function automatic logic [ENTRY_W-1:0] pack_entry(input entry_t e);
    return e;
  endfunction
  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] v);
    return entry_t'(v);
  endfunction
  // BG scroll and mode-7 registers written as two successive bytes
  function automatic logic is_double_reg(input logic [7:0] pa);
    return (pa >= 8'h0D && pa <= 8'h14) || (pa >= 8'h1B && pa <= 8'h20);
  endfunction
  function automatic logic is_cpu_reg(input logic [23:0] a);
    return !a[22] && (a[15:4] == 12'h420 || a[15:8] == 8'h43);
  endfunction
endpackage

// File: rtl/ctx_sync_fifo.sv
// ctx_sync_fifo: single-clock FIFO; push while full is ignored unless a pop frees the slot.
module ctx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 41
) (
  input  logic                       clkin,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_lvl;
  logic w_pu, w_po;
  assign o_empty = r_lvl == '0;
  assign o_full = r_lvl == (AW+1)'(DEPTH);
  assign o_level = r_lvl;
  assign o_data = r_mem[r_rp];
  assign w_po = i_pop && !o_empty;
  assign w_pu = i_push && (!o_full || w_po);
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_lvl <= '0;
    end else begin
      if (w_pu) r_wp <= r_wp + 1'b1;
      if (w_po) r_rp <= r_rp + 1'b1;
      r_lvl <= (w_pu && !w_po) ? r_lvl + 1'b1 : (w_po && !w_pu) ? r_lvl - 1'b1 : r_lvl;
    end
  always_ff @(posedge clkin)
    if (w_pu) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/ctx_snoop_queue.sv
// ctx_snoop_queue: decodes SNES bus writes into shadow-SRAM write requests and
// queues them for the SRAM arbiter with overflow counting.
module ctx_snoop_queue
  import ctx_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          OVF_W     = 8,
  parameter logic [23:0] BASE_WRAM = 24'hF50000,
  parameter logic [23:0] BASE_VRAM = 24'hF70000,
  parameter logic [23:0] BASE_REGS = 24'hF90000
) (
  input  logic                      clkin,
  input  logic                      reset_n,
  input  logic [23:0]               SNES_ADDR,
  input  logic [7:0]                SNES_PA,
  input  logic                      SNES_WR_end,
  input  logic                      SNES_PAWR_end,
  input  logic                      SNES_PARD_end,
  input  logic [7:0]                SNES_DATA_IN,
  input  logic [5:0]                region_en,
  output logic                      BUS_WRQ,
  input  logic                      BUS_RDY,
  output logic [23:0]               ROM_ADDR,
  output logic [15:0]               ROM_DATA,
  output logic                      ROM_WORD_ENABLE,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [OVF_W-1:0]          ovf_count
);
  logic w_wr, w_pw, w_pr, w_wram_hit, w_vinc, w_cap_v, w_push, w_pop, w_full, w_empty;
  logic [16:0] w_wram_ofs, r_wram_addr;
  logic [14:0] r_vram_addr, w_vstep, w_vmap;
  logic [4:0] r_2115;
  logic [7:0] r_cg_idx, r_cg_lo, r_oam_lo, r_ppu_prev, d;
  logic r_cg_ph;
  logic [9:0] r_oam_addr;
  logic [OVF_W-1:0] r_ovf;
  logic [ENTRY_W-1:0] w_head_bits;
  region_e w_cap_rg;
  entry_t w_cap, w_head, w_out, r_last;
  assign d = SNES_DATA_IN;
  assign w_wr = SNES_WR_end;
  assign w_pw = SNES_PAWR_end && !SNES_WR_end;
  assign w_pr = SNES_PARD_end && !SNES_WR_end && !SNES_PAWR_end;
  assign w_wram_hit = SNES_ADDR[23:17] == 7'h3F || (!SNES_ADDR[22] && SNES_ADDR[15:13] == 3'd0);
  assign w_wram_ofs = SNES_ADDR[23:17] == 7'h3F ? SNES_ADDR[16:0] : {4'd0, SNES_ADDR[12:0]};
  // r_2115 keeps only the VMAIN fields in use: {inc_on_high, remap[1:0], step[1:0]}
  assign w_vstep = r_2115[1:0] == 2'd0 ? 15'd1 : r_2115[1:0] == 2'd1 ? 15'd32 : 15'd128;
  assign w_vmap = r_2115[3:2] == 2'd1 ? {r_vram_addr[14:8], r_vram_addr[4:0], r_vram_addr[7:5]} :
                  r_2115[3:2] == 2'd2 ? {r_vram_addr[14:9], r_vram_addr[5:0], r_vram_addr[8:6]} :
                  r_2115[3:2] == 2'd3 ? {r_vram_addr[14:10], r_vram_addr[6:0], r_vram_addr[9:7]} :
                  r_vram_addr;
  assign w_vinc = r_2115[4] ? ((w_pw && SNES_PA == PA_VMDATAH) || (w_pr && SNES_PA == PA_VMRDH))
                            : ((w_pw && SNES_PA == PA_VMDATAL) || (w_pr && SNES_PA == PA_VMRDL));
  always_comb begin
    w_cap_v = 1'b0;
    w_cap_rg = RG_WRAM;
    w_cap = '0;
    if (w_wr && w_wram_hit) begin
      w_cap_v = 1'b1;
      w_cap = make_entry(BASE_WRAM + {7'd0, w_wram_ofs}, {8'd0, d}, 1'b0);
    end else if (w_wr && is_cpu_reg(SNES_ADDR)) begin
      w_cap_v = 1'b1;
      w_cap_rg = RG_CPU;
      w_cap = make_entry(BASE_REGS + OFS_CPU + {15'd0, SNES_ADDR[8:0]}, {8'd0, d}, 1'b0);
    end else if (w_pw) begin
      if (SNES_PA == PA_WMDATA) begin
        w_cap_v = 1'b1;
        w_cap = make_entry(BASE_WRAM + {7'd0, r_wram_addr}, {8'd0, d}, 1'b0);
      end else if (SNES_PA == PA_VMDATAL || SNES_PA == PA_VMDATAH) begin
        w_cap_v = 1'b1;
        w_cap_rg = RG_VRAM;
        w_cap = make_entry(BASE_VRAM + {8'd0, w_vmap, SNES_PA[0]}, {8'd0, d}, 1'b0);
      end else if (SNES_PA == PA_CGDATA && r_cg_ph) begin
        w_cap_v = 1'b1;
        w_cap_rg = RG_CGRAM;
        w_cap = make_entry(BASE_REGS + OFS_CGRAM + {15'd0, r_cg_idx, 1'b0}, {d, r_cg_lo}, 1'b1);
      end else if (SNES_PA == PA_OAMDATA && (r_oam_addr[9] || r_oam_addr[0])) begin
        w_cap_v = 1'b1;
        w_cap_rg = RG_OAM;
        w_cap = r_oam_addr[9] ? make_entry(BASE_REGS + OFS_OAM + {14'd0, r_oam_addr & 10'h21F}, {8'd0, d}, 1'b0)
                              : make_entry(BASE_REGS + OFS_OAM + {14'd0, r_oam_addr[9:1], 1'b0}, {d, r_oam_lo}, 1'b1);
      end else if (is_double_reg(SNES_PA)) begin
        w_cap_v = 1'b1;
        w_cap_rg = RG_PPU;
        w_cap = make_entry(BASE_REGS + OFS_PPU + {15'd0, SNES_PA, 1'b0}, {d, r_ppu_prev}, 1'b1);
      end
    end
  end
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) begin
      r_wram_addr <= '0;
      r_vram_addr <= '0;
      r_2115 <= '0;
      r_cg_idx <= '0;
      r_cg_lo <= '0;
      r_cg_ph <= 1'b0;
      r_oam_addr <= '0;
      r_oam_lo <= '0;
      r_ppu_prev <= '0;
    end else begin
      if (w_pw && SNES_PA == PA_WMADDL) r_wram_addr[7:0] <= d;
      else if (w_pw && SNES_PA == PA_WMADDM) r_wram_addr[15:8] <= d;
      else if (w_pw && SNES_PA == PA_WMADDH) r_wram_addr[16] <= d[0];
      else if ((w_pw || w_pr) && SNES_PA == PA_WMDATA) r_wram_addr <= r_wram_addr + 1'b1;
      if (w_pw && SNES_PA == PA_VMAIN) r_2115 <= {d[7], d[3:0]};
      if (w_pw && SNES_PA == PA_VMADDL) r_vram_addr[7:0] <= d;
      else if (w_pw && SNES_PA == PA_VMADDH) r_vram_addr[14:8] <= d[6:0];
      else if (w_vinc) r_vram_addr <= r_vram_addr + w_vstep;
      if (w_pw && SNES_PA == PA_CGADD) begin
        r_cg_idx <= d;
        r_cg_ph <= 1'b0;
      end else if (w_pw && SNES_PA == PA_CGDATA) begin
        r_cg_ph <= !r_cg_ph;
        if (!r_cg_ph) r_cg_lo <= d;
        else r_cg_idx <= r_cg_idx + 1'b1;
      end
      if (w_pw && SNES_PA == PA_OAMADDL) r_oam_addr <= {r_oam_addr[9], d, 1'b0};
      else if (w_pw && SNES_PA == PA_OAMADDH) r_oam_addr <= {d[0], r_oam_addr[8:1], 1'b0};
      else if ((w_pw && SNES_PA == PA_OAMDATA) || (w_pr && SNES_PA == PA_OAMREAD)) r_oam_addr <= r_oam_addr + 1'b1;
      if (w_pw && SNES_PA == PA_OAMDATA && !r_oam_addr[0]) r_oam_lo <= d;
      if (w_pw && is_double_reg(SNES_PA)) r_ppu_prev <= d;
    end
  assign w_push = w_cap_v && region_en[w_cap_rg];
  assign w_pop = BUS_WRQ && BUS_RDY;
  ctx_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clkin   (clkin),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (pack_entry(w_cap)),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );
  assign w_head = unpack_entry(w_head_bits);
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) begin
      r_ovf <= '0;
      r_last <= '0;
    end else begin
      if (w_push && w_full && !w_pop && !(&r_ovf)) r_ovf <= r_ovf + 1'b1;
      if (w_pop) r_last <= w_head;
    end
  assign BUS_WRQ = !w_empty;
  assign w_out = BUS_WRQ ? w_head : r_last;
  assign ROM_ADDR = w_out.addr;
  assign ROM_DATA = w_out.data;
  assign ROM_WORD_ENABLE = w_out.word;
  assign ovf_count = r_ovf;
endmodule

// File: tb/tb_ctx_snoop_queue.sv
// tb_ctx_snoop_queue: directed checks of capture decode, queueing, overflow and reset.
module tb_ctx_snoop_queue;
  logic clkin = 1'b0, reset_n = 1'b0;
  logic [23:0] SNES_ADDR = '0;
  logic [7:0] SNES_PA = '0, SNES_DATA_IN = '0;
  logic SNES_WR_end = 1'b0, SNES_PAWR_end = 1'b0, SNES_PARD_end = 1'b0;
  logic [5:0] region_en = 6'h3F;
  logic BUS_WRQ, BUS_RDY = 1'b0, ROM_WORD_ENABLE;
  logic [23:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic [3:0] fifo_level;
  logic [7:0] ovf_count;
  int n_cmp = 0, n_err = 0;
  logic [23:0] exp_a [7];
  logic [15:0] exp_d [7];
  logic exp_w [7];

  always #5 clkin = ~clkin;

  ctx_snoop_queue dut (
    .clkin(clkin), .reset_n(reset_n), .SNES_ADDR(SNES_ADDR), .SNES_PA(SNES_PA),
    .SNES_WR_end(SNES_WR_end), .SNES_PAWR_end(SNES_PAWR_end), .SNES_PARD_end(SNES_PARD_end),
    .SNES_DATA_IN(SNES_DATA_IN), .region_en(region_en), .BUS_WRQ(BUS_WRQ), .BUS_RDY(BUS_RDY),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .ROM_WORD_ENABLE(ROM_WORD_ENABLE),
    .fifo_level(fifo_level), .ovf_count(ovf_count)
  );

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [23:0] a, input logic [15:0] d, input logic w);
    chk({tag, ".wrq"}, 64'(BUS_WRQ), 64'd1);
    chk({tag, ".addr"}, 64'(ROM_ADDR), 64'(a));
    chk({tag, ".data"}, 64'(ROM_DATA), 64'(d));
    chk({tag, ".word"}, 64'(ROM_WORD_ENABLE), 64'(w));
  endtask

  task automatic cpu_wr(input logic [23:0] a, input logic [7:0] d);
    SNES_ADDR = a;
    SNES_DATA_IN = d;
    SNES_WR_end = 1'b1;
    tick;
    SNES_WR_end = 1'b0;
  endtask

  task automatic pa_wr(input logic [7:0] pa, input logic [7:0] d);
    SNES_PA = pa;
    SNES_DATA_IN = d;
    SNES_PAWR_end = 1'b1;
    tick;
    SNES_PAWR_end = 1'b0;
  endtask

  task automatic pa_rd(input logic [7:0] pa);
    SNES_PA = pa;
    SNES_PARD_end = 1'b1;
    tick;
    SNES_PARD_end = 1'b0;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst.wrq", 64'(BUS_WRQ), 64'd0);
    chk("rst.addr", 64'(ROM_ADDR), 64'd0);
    chk("rst.data", 64'(ROM_DATA), 64'd0);
    chk("rst.word", 64'(ROM_WORD_ENABLE), 64'd0);
    chk("rst.level", 64'(fifo_level), 64'd0);
    chk("rst.ovf", 64'(ovf_count), 64'd0);
    reset_n = 1'b1;
    tick;
    // WRAM direct write, arbiter ready
    BUS_RDY = 1'b1;
    cpu_wr(24'h7E1234, 8'hAA);
    chk_head("wram", 24'hF51234, 16'h00AA, 1'b0);
    chk("wram.level", 64'(fifo_level), 64'd1);
    tick;
    chk("wram.popped", 64'(BUS_WRQ), 64'd0);
    chk("wram.hold_addr", 64'(ROM_ADDR), 64'hF51234);
    chk("wram.hold_data", 64'(ROM_DATA), 64'h00AA);
    // VRAM with increment on high byte
    BUS_RDY = 1'b0;
    pa_wr(8'h15, 8'h80);
    pa_wr(8'h16, 8'h00);
    pa_wr(8'h17, 8'h10);
    pa_wr(8'h18, 8'h11);
    pa_wr(8'h19, 8'h22);
    pa_wr(8'h18, 8'h33);
    chk("vram.level", 64'(fifo_level), 64'd3);
    BUS_RDY = 1'b1;
    chk_head("vram0", 24'hF72000, 16'h0011, 1'b0);
    tick;
    chk_head("vram1", 24'hF72001, 16'h0022, 1'b0);
    tick;
    chk_head("vram2", 24'hF72002, 16'h0033, 1'b0);
    tick;
    chk("vram.empty", 64'(fifo_level), 64'd0);
    // CGRAM byte pair
    pa_wr(8'h21, 8'h05);
    chk("cg.l0", 64'(fifo_level), 64'd0);
    pa_wr(8'h22, 8'h34);
    chk("cg.l1", 64'(fifo_level), 64'd0);
    pa_wr(8'h22, 8'h12);
    chk("cg.l2", 64'(fifo_level), 64'd1);
    chk_head("cg", 24'hF9000A, 16'h1234, 1'b1);
    tick;
    chk("cg.l3", 64'(fifo_level), 64'd0);
    // suppressed VRAM capture still advances the address
    BUS_RDY = 1'b0;
    pa_wr(8'h15, 8'h00);
    region_en = 6'h3D;
    pa_wr(8'h18, 8'h55);
    chk("vdis.level", 64'(fifo_level), 64'd0);
    region_en = 6'h3F;
    pa_wr(8'h18, 8'h66);
    pa_wr(8'h81, 8'h10);
    pa_wr(8'h82, 8'h00);
    pa_wr(8'h83, 8'h01);
    pa_wr(8'h80, 8'h77);
    pa_rd(8'h80);
    pa_wr(8'h80, 8'h88);
    pa_wr(8'h02, 8'h00);
    pa_wr(8'h03, 8'h01);
    pa_wr(8'h04, 8'h9A);
    pa_wr(8'h02, 8'h03);
    pa_wr(8'h03, 8'h00);
    pa_wr(8'h04, 8'hCD);
    pa_wr(8'h04, 8'hAB);
    pa_wr(8'h0D, 8'h11);
    pa_wr(8'h0D, 8'h22);
    chk("mix.level", 64'(fifo_level), 64'd7);
    exp_a = '{24'hF72004, 24'hF60010, 24'hF60012, 24'hF90400, 24'hF90206, 24'hF9051A, 24'hF9051A};
    exp_d = '{16'h0066, 16'h0077, 16'h0088, 16'h009A, 16'hABCD, 16'h1100, 16'h2211};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    BUS_RDY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk_head($sformatf("mix%0d", i), exp_a[i], exp_d[i], exp_w[i]);
      tick;
    end
    chk("mix.empty", 64'(fifo_level), 64'd0);
    // overflow: 10 writes into an 8-deep queue
    BUS_RDY = 1'b0;
    for (int i = 0; i < 10; i++) cpu_wr(24'h004200 + 24'(i), 8'h10 + 8'(i));
    chk("ovf.level", 64'(fifo_level), 64'd8);
    chk("ovf.count", 64'(ovf_count), 64'd2);
    BUS_RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("ovf%0d", i), 24'hF90700 + 24'(i), 16'h0010 + 16'(i), 1'b0);
      tick;
    end
    chk("ovf.empty", 64'(fifo_level), 64'd0);
    // full with simultaneous push and pop
    BUS_RDY = 1'b0;
    for (int i = 0; i < 8; i++) cpu_wr(24'h004300 + 24'(i), 8'(i));
    chk("fp.full", 64'(fifo_level), 64'd8);
    BUS_RDY = 1'b1;
    cpu_wr(24'h004308, 8'h08);
    chk("fp.level", 64'(fifo_level), 64'd8);
    chk("fp.ovf", 64'(ovf_count), 64'd2);
    chk_head("fp", 24'hF90801, 16'h0001, 1'b0);
    repeat (3) tick;
    BUS_RDY = 1'b0;
    chk("pre_rst.level", 64'(fifo_level), 64'd5);
    chk_head("pre_rst", 24'hF90804, 16'h0004, 1'b0);
    // asynchronous reset mid-transfer
    #2 reset_n = 1'b0;
    #1;
    chk("arst.wrq", 64'(BUS_WRQ), 64'd0);
    chk("arst.level", 64'(fifo_level), 64'd0);
    chk("arst.ovf", 64'(ovf_count), 64'd0);
    chk("arst.addr", 64'(ROM_ADDR), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
